spi_ram_port: RTL and testbench
===============================

Name: spi_ram_port

Overview:
- Single-port synchronous RAM stage directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid word stream: bits [9:8] are the command, bits [7:0] the payload.
- Returns read data to the slave on dout/tx_valid for serialisation on MISO.
- Tracks address-register validity and flags command-sequence errors.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, address width; legal range 1..8. The address is din[ADDR_SIZE-1:0]; higher din payload bits are ignored for addressing.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  10  command/payload word from the SPI slave (rx_data)
- rx_valid  in  1  din qualifier; one-cycle pulse per word
- dout  out  8  read data to the SPI slave (tx_data)
- tx_valid  out  1  dout qualifier; one-cycle pulse
- cmd_err  out  1  one-cycle pulse on an illegal command sequence

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n): on assertion, all registers clear immediately, without waiting for a clock edge.
- Reset values:
  - dout = 8'h00, tx_valid = 0, cmd_err = 0
  - wr_addr = 0, rd_addr = 0, wr_addr_vld = 0, rd_addr_vld = 0
  - Memory array is NOT reset; contents are undefined until written.
- rx_valid = 0: no state change. tx_valid and cmd_err return to 0. dout holds its value.
- rx_valid = 1, decode din[9:8] at the rising edge:
  - 2'b00 WR_ADDR: wr_addr <= din[ADDR_SIZE-1:0]; wr_addr_vld <= 1.
  - 2'b01 WR_DATA: if wr_addr_vld, mem[wr_addr] <= din[7:0]. Otherwise no write and cmd_err = 1 for one cycle.
  - 2'b10 RD_ADDR: rd_addr <= din[ADDR_SIZE-1:0]; rd_addr_vld <= 1.
  - 2'b11 RD_DATA: if rd_addr_vld, dout <= mem[rd_addr] and tx_valid = 1 for one cycle. Otherwise dout unchanged, tx_valid stays 0, cmd_err = 1 for one cycle.
- Latency: outputs are registered and visible after the same edge that samples rx_valid.
  - tx_valid is high exactly one cycle per accepted RD_DATA.
  - Back-to-back RD_DATA words give back-to-back tx_valid pulses.
- Address validity flags persist until reset. Repeated WR_DATA targets the same wr_addr; repeated RD_DATA reads the same rd_addr (unless the optional feature below is enabled).
- Write/read separation: wr_addr and rd_addr are independent registers.
  - RD_DATA returns memory contents as of the previous edge; there is no same-cycle bypass (only one word arrives per cycle).
  - A WR_DATA followed by RD_DATA to the same address in a later cycle returns the new data.
- Reset mid-operation: a tx_valid pulse in flight is cleared immediately. After reset deassertion, RD_DATA without a fresh RD_ADDR raises cmd_err.
- X-safety: while rx_valid = 0, din is never decoded.
- cmd_err and tx_valid are never high in the same cycle.

Optional Feature:
- Macro: RAM_ADDR_AUTOINC_EN.
- Defined:
  - After each accepted WR_DATA, wr_addr <= wr_addr + 1.
  - After each accepted RD_DATA, rd_addr <= rd_addr + 1.
  - Both wrap modulo MEM_DEPTH (MEM_DEPTH-1 -> 0).
  - Rejected (cmd_err) words do not increment.
- Undefined: addresses change only on WR_ADDR/RD_ADDR; behaviour exactly as described above.

Test Plan:
- Reset: assert rst_n = 0 mid-cycle while tx_valid = 1 -> tx_valid, dout, cmd_err go to 0 before the next clk edge; RD_DATA after release -> cmd_err = 1, tx_valid = 0.
- Write/read: din = 10'h0_3C (WR_ADDR 0x3C), then 10'h1_A5, then 10'h2_3C, then 10'h3_00 -> tx_valid = 1 for one cycle with dout = 8'hA5 after the fourth edge.
- Sequence errors: from reset, din = 10'h1_55 -> cmd_err pulse, mem unchanged; then din = 10'h3_00 -> cmd_err pulse, tx_valid = 0, dout = 8'h00.
- Idle stability: rx_valid = 0 for 20 cycles with random din -> no output or address change; dout holds the last read value.
- Back-to-back reads: after RD_ADDR 0x3C, two consecutive RD_DATA words -> two consecutive tx_valid cycles, both dout = 8'hA5 (feature off).
- With RAM_ADDR_AUTOINC_EN: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, then RD_ADDR 0xFF, RD_DATA x2 -> dout 0x11 then 0x22, with address wrap to 0x00.

Source files
------------

// File: rtl/spi_ram_port_if.sv
// Word-stream link between the SPI slave and the RAM port.
// The master side (SPI slave) drives command words; the slave side (RAM port)
// returns read data plus status pulses.
interface spi_ram_port_if;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       cmd_err;

    modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
    modport slave  (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram_port.sv
// Single-port RAM stage behind the SPI slave.
// din[9:8] selects WR_ADDR / WR_DATA / RD_ADDR / RD_DATA, din[7:0] is payload.
// Data commands issued before their address register is loaded are rejected
// with a one-cycle cmd_err pulse.
// Optional: RAM_ADDR_AUTOINC_EN post-increments the relevant address after
// every accepted data word (wrapping at MEM_DEPTH).
module spi_ram_port #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    spi_ram_port_if.slave  bus
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic                 wr_addr_vld, rd_addr_vld;
    logic [7:0]           dout_q;
    logic                 tx_valid_q, cmd_err_q;
    cmd_t                 cmd;
    logic                 wr_en, rd_en;

    assign cmd = cmd_t'(bus.din[9:8]);

    // Accepted data commands; din is only decoded while rx_valid is high.
    always_comb begin
        wr_en = 1'b0;
        rd_en = 1'b0;
        if (bus.rx_valid) begin
            wr_en = (cmd == CMD_WR_DATA) && wr_addr_vld;
            rd_en = (cmd == CMD_RD_DATA) && rd_addr_vld;
        end
    end

    // Memory array write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= bus.din[7:0];
    end

    // Address registers, validity flags, registered read data and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            rd_addr     <= '0;
            wr_addr_vld <= 1'b0;
            rd_addr_vld <= 1'b0;
            dout_q      <= 8'h00;
            tx_valid_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            cmd_err_q  <= 1'b0;
            if (bus.rx_valid) begin
                case (cmd)
                    CMD_WR_ADDR: begin
                        wr_addr     <= bus.din[ADDR_SIZE-1:0];
                        wr_addr_vld <= 1'b1;
                    end
                    CMD_WR_DATA: begin
                        if (!wr_addr_vld) cmd_err_q <= 1'b1;
`ifdef RAM_ADDR_AUTOINC_EN
                        else wr_addr <= wr_addr + 1'b1;
`endif
                    end
                    CMD_RD_ADDR: begin
                        rd_addr     <= bus.din[ADDR_SIZE-1:0];
                        rd_addr_vld <= 1'b1;
                    end
                    CMD_RD_DATA: begin
                        if (rd_en) begin
                            dout_q     <= mem[rd_addr];
                            tx_valid_q <= 1'b1;
`ifdef RAM_ADDR_AUTOINC_EN
                            rd_addr    <= rd_addr + 1'b1;
`endif
                        end else begin
                            cmd_err_q <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_port.sv
// Directed bench for spi_ram_port: a vector table for the main command flow
// plus hand-written sequences for idle, mid-cycle reset, retention across
// reset and (when RAM_ADDR_AUTOINC_EN is defined) address auto-increment.
module tb_spi_ram_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    spi_ram_port_if bus ();

    spi_ram_port #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [9:0] din;
        logic       tx;
        logic [7:0] dout;
        logic       err;
        logic       chk_dout;
    } vec_t;

    vec_t vecs [20];
    int   nvec = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one word at the falling edge, sample 1 ns after the next rising edge.
    task automatic step(input logic rv, input logic [9:0] d);
        @(negedge clk);
        bus.rx_valid = rv;
        bus.din      = d;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic chk_out(input string name, input logic tx, input logic [7:0] dv, input logic err);
        chk({name, ".tx_valid"}, {7'd0, bus.tx_valid}, {7'd0, tx});
        chk({name, ".dout"},     bus.dout, dv);
        chk({name, ".cmd_err"},  {7'd0, bus.cmd_err}, {7'd0, err});
    endtask

    task automatic add(input logic rv, input logic [9:0] d, input logic tx,
                       input logic [7:0] dv, input logic err, input logic cd);
        vecs[nvec] = '{rv, d, tx, dv, err, cd};
        nvec++;
    endtask

    logic [7:0] held;
    logic       autoinc;

    initial begin
`ifdef RAM_ADDR_AUTOINC_EN
        autoinc = 1'b1;
`else
        autoinc = 1'b0;
`endif
        bus.rx_valid = 1'b0;
        bus.din      = 10'h000;

        // Sequence errors from reset, then basic write/read and back-to-back reads.
        add(1, 10'h155, 0, 8'h00, 1, 1);   // WR_DATA before WR_ADDR
        add(1, 10'h300, 0, 8'h00, 1, 1);   // RD_DATA before RD_ADDR
        add(1, 10'h03C, 0, 8'h00, 0, 1);   // WR_ADDR 3C
        add(1, 10'h1A5, 0, 8'h00, 0, 1);   // WR_DATA A5
        add(1, 10'h23C, 0, 8'h00, 0, 1);   // RD_ADDR 3C
        add(1, 10'h300, 1, 8'hA5, 0, 1);   // RD_DATA -> A5
        add(1, 10'h300, 1, 8'hA5, 0, !autoinc); // back-to-back read
        add(0, 10'h3FF, 0, 8'hA5, 0, !autoinc); // idle, RD_DATA pattern not decoded
        add(1, 10'h010, 0, 8'hA5, 0, !autoinc); // WR_ADDR 10
        add(1, 10'h15A, 0, 8'hA5, 0, !autoinc); // WR_DATA 5A
        add(1, 10'h210, 0, 8'hA5, 0, !autoinc); // RD_ADDR 10
        add(1, 10'h300, 1, 8'h5A, 0, 1);   // RD_DATA -> 5A
        add(1, 10'h0FF, 0, 8'h5A, 0, 1);   // WR_ADDR FF (top of range)
        add(1, 10'h1C3, 0, 8'h5A, 0, 1);   // WR_DATA C3
        add(1, 10'h23C, 0, 8'h5A, 0, 1);   // RD_ADDR 3C: 3C not clobbered
        add(1, 10'h300, 1, 8'hA5, 0, 1);
        add(1, 10'h2FF, 0, 8'hA5, 0, 1);   // RD_ADDR FF
        add(1, 10'h3AB, 1, 8'hC3, 0, 1);   // RD_DATA payload ignored -> C3

        // Reset state.
        #12;
        chk_out("reset", 0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < nvec; i++) begin
            step(vecs[i].rv, vecs[i].din);
            chk($sformatf("vec%0d.tx_valid", i), {7'd0, bus.tx_valid}, {7'd0, vecs[i].tx});
            chk($sformatf("vec%0d.cmd_err", i),  {7'd0, bus.cmd_err},  {7'd0, vecs[i].err});
            if (vecs[i].chk_dout)
                chk($sformatf("vec%0d.dout", i), bus.dout, vecs[i].dout);
        end

        // Idle stability: random din with rx_valid low must not disturb anything.
        step(1, 10'h23C);
        step(1, 10'h300);
        chk_out("idle_pre", 1, 8'hA5, 0);
        held = bus.dout;
        for (int i = 0; i < 20; i++) begin
            step(0, 10'($urandom));
            chk_out($sformatf("idle%0d", i), 0, held, 0);
        end
        if (!autoinc) begin
            step(1, 10'h300);                // rd_addr still 3C
            chk_out("idle_post_rd", 1, 8'hA5, 0);
        end

        // Mid-cycle reset with a tx_valid pulse in flight; mem[00] = 77 beforehand.
        step(1, 10'h000);
        step(1, 10'h177);
        step(1, 10'h23C);
        step(1, 10'h300);
        chk_out("pre_rst", 1, 8'hA5, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 0, 8'h00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 10'h300);                    // rd_addr_vld cleared
        chk_out("rd_after_rst", 0, 8'h00, 1);
        step(1, 10'h155);                    // wr_addr_vld cleared, write rejected
        chk_out("wr_after_rst", 0, 8'h00, 1);
        step(1, 10'h200);
        step(1, 10'h300);                    // mem survives reset, rejected write didn't land
        chk_out("retained", 1, 8'h77, 0);

`ifdef RAM_ADDR_AUTOINC_EN
        step(1, 10'h0FF);
        step(1, 10'h111);
        step(1, 10'h122);                    // lands at 00 after wrap
        step(1, 10'h2FF);
        step(1, 10'h300);
        chk_out("inc_rd0", 1, 8'h11, 0);
        step(1, 10'h300);
        chk_out("inc_rd1", 1, 8'h22, 0);
        step(1, 10'h200);
        step(1, 10'h300);
        chk_out("inc_wrap", 1, 8'h22, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
